stg5wb_gpregs: RTL and testbench
================================

# stg5wb_gpregs

Write-back stage and general-purpose register file for the diad pipeline. Captures the final result from the memory stage and holds it for one cycle in the write-back latch, which also drives the MO→WB forwarding bus into execute. The following edge commits the value into the GP array. Serves the two combinational GP read ports that execute drives with its source and target register addresses.

## Interface
Parameters:
- DATA_W, 24, data/result width
- GP_AW, 4, GP register address width (2**GP_AW registers)
- CNT_W, 16, retire counter width

Ports:
- iw_clk  in  1  clock, all state on rising edge
- iw_rst_n  in  1  reset, asynchronous and active-low
- iw_tgt_gp  in  GP_AW  destination register from memory stage
- iw_tgt_gp_we  in  1  destination write enable from memory stage
- iw_result  in  DATA_W  result from memory stage
- iw_flush  in  1  kill incoming instruction (forces latched we to 0)
- iw_gp_read_addr1  in  GP_AW  read port 1 address (execute source)
- iw_gp_read_addr2  in  GP_AW  read port 2 address (execute target)
- ow_gp_read_data1  out  DATA_W  read port 1 data, combinational
- ow_gp_read_data2  out  DATA_W  read port 2 data, combinational
- ow_tgt_mowb_gp  out  GP_AW  latched destination (forwarding to execute)
- ow_tgt_mowb_gp_we  out  1  latched write enable (forwarding to execute)
- ow_mowb_result  out  DATA_W  latched result (forwarding to execute)
- ow_retire_cnt  out  CNT_W  count of committed GP writes

## Operation
- WB latch state: tgt, we, result. At each edge the latch loads iw_tgt_gp, iw_tgt_gp_we & ~iw_flush, and iw_result.
- Commit: at each edge where the latch we=1, the array entry at latch tgt is loaded with the latch result. This is the same edge on which the latch reloads. The array is written only from the latch, never directly from the inputs.
- Retire counter: +1 on each commit edge. It wraps modulo 2**CNT_W with no saturation.
- Reads: ow_gp_read_dataN = array[iw_gp_read_addrN]. The bypass override is described under Configuration. The two ports are independent, and equal addresses are legal.
- All registers are writable, including register 0. There is no hardwired zero.
- Back-to-back writes to the same register: each is committed in order, and the later one wins.
- iw_flush affects only the incoming instruction. It has no effect on a value already in the latch.

## Timing
- Reset (iw_rst_n=0, asynchronous): all array entries are 0. Latch tgt=0, we=0, result=0, so ow_tgt_mowb_gp=0, ow_tgt_mowb_gp_we=0, ow_mowb_result=0. ow_retire_cnt=0. Read data = 0.
- Reset asserted mid-operation: a pending latch write is discarded, not committed, and the counter does not count it.
- Latency: an input presented before edge E appears on the forwarding outputs after edge E. It is present in the array after edge E+1. The counter reflects it after edge E+1.
- Read ports are purely combinational with zero cycles of latency. An array update at edge E+1 is visible on reads immediately after that edge.
- Deassertion of iw_rst_n is synchronised externally. The first edge after release behaves normally.

## Configuration
- Macro GPREGS_BYPASS_EN.
- Defined: when the latch we=1 and latch tgt equals iw_gp_read_addrN, ow_gp_read_dataN returns the latch result instead of the array content (write-through bypass). Each port is evaluated independently.
- Undefined: reads always return array content. Execute must cover the WB-latch hazard through its own MO/WB forwarding path using ow_tgt_mowb_*.

## Test plan
- Reset then read: assert iw_rst_n=0 mid-run with the latch holding we=1, tgt=3, result=0x00ABCD. Release, then read addr 3 on both ports -> data 0, retire_cnt=0, ow_tgt_mowb_gp_we=0.
- Basic write: tgt=5, we=1, result=0x123456 before edge E.
  - After E: ow_mowb_result=0x123456 and ow_tgt_mowb_gp=5.
  - Reading addr 5 after E returns 0x123456 with GPREGS_BYPASS_EN, or 0 without it.
  - After E+1: reads return 0x123456 in both builds, and retire_cnt=1.
- Flush: tgt=7, we=1, result=0xFFFFFF with iw_flush=1 -> after E, ow_tgt_mowb_gp_we=0. After E+1, addr 7 still reads 0 and retire_cnt is unchanged.
- Back-to-back: write r2=0x000011, then r2=0x000022 on consecutive edges -> after the final commit, r2 reads 0x000022 on both ports and retire_cnt has advanced by 2.
- Dual port, same address: both ports read r9 while r9 is being committed -> both ports return identical data every cycle.
- Counter wrap: with CNT_W=4, perform 17 committed writes -> ow_retire_cnt=1.

Source files
------------

// File: rtl/stg5wb_gpregs.sv
`default_nettype none
// ============================================================================
// Module   : stg5wb_gpregs
// Purpose  : Write-back latch, general-purpose register file (two combinational
//            read ports) and retire counter. The optional write-through bypass
//            is enabled by defining GPREGS_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module stg5wb_gpregs #(
  parameter int DATA_W = 24,
  parameter int GP_AW  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              iw_clk,
  input  logic              iw_rst_n,
  input  logic [GP_AW-1:0]  iw_tgt_gp,
  input  logic              iw_tgt_gp_we,
  input  logic [DATA_W-1:0] iw_result,
  input  logic              iw_flush,
  input  logic [GP_AW-1:0]  iw_gp_read_addr1,
  input  logic [GP_AW-1:0]  iw_gp_read_addr2,
  output logic [DATA_W-1:0] ow_gp_read_data1,
  output logic [DATA_W-1:0] ow_gp_read_data2,
  output logic [GP_AW-1:0]  ow_tgt_mowb_gp,
  output logic              ow_tgt_mowb_gp_we,
  output logic [DATA_W-1:0] ow_mowb_result,
  output logic [CNT_W-1:0]  ow_retire_cnt
);

  localparam int c_NUM_REGS = 2 ** GP_AW;

  logic [GP_AW-1:0]  r_tgt;
  logic              r_we;
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] r_gp [c_NUM_REGS];
  logic [CNT_W-1:0]  r_retire_cnt;
  logic [c_NUM_REGS-1:0] w_wr_sel;
  logic              w_byp1;
  logic              w_byp2;

  // WB latch: a flush kills only the incoming instruction's write enable.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      r_tgt    <= '0;
      r_we     <= 1'b0;
      r_result <= '0;
    end else begin
      r_tgt    <= iw_tgt_gp;
      r_we     <= iw_tgt_gp_we & ~iw_flush;
      r_result <= iw_result;
    end
  end

  for (genvar gi = 0; gi < c_NUM_REGS; gi++) begin : g_wdec
    assign w_wr_sel[gi] = r_we && (r_tgt == GP_AW'(gi));
  end

  // The array is only ever loaded from the latch, on the edge after capture.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      for (int i = 0; i < c_NUM_REGS; i++) begin
        r_gp[i] <= '0;
      end
    end else begin
      for (int i = 0; i < c_NUM_REGS; i++) begin
        if (w_wr_sel[i]) begin
          r_gp[i] <= r_result;
        end
      end
    end
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      r_retire_cnt <= '0;
    end else if (r_we) begin
      r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

`ifdef GPREGS_BYPASS_EN
  assign w_byp1 = r_we && (r_tgt == iw_gp_read_addr1);
  assign w_byp2 = r_we && (r_tgt == iw_gp_read_addr2);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  assign ow_gp_read_data1  = w_byp1 ? r_result : r_gp[iw_gp_read_addr1];
  assign ow_gp_read_data2  = w_byp2 ? r_result : r_gp[iw_gp_read_addr2];
  assign ow_tgt_mowb_gp    = r_tgt;
  assign ow_tgt_mowb_gp_we = r_we;
  assign ow_mowb_result    = r_result;
  assign ow_retire_cnt     = r_retire_cnt;

endmodule
`default_nettype wire

// File: tb/tb_stg5wb_gpregs.sv
`default_nettype none
// ============================================================================
// Module   : tb_stg5wb_gpregs
// Purpose  : Self-checking bench for stg5wb_gpregs (table vectors, reset and
//            wrap sequences, randomized traffic against a reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stg5wb_gpregs;

`ifdef GPREGS_BYPASS_EN
  localparam bit c_BYP = 1'b1;
`else
  localparam bit c_BYP = 1'b0;
`endif

  logic        iw_clk = 1'b0;
  logic        iw_rst_n;
  logic [3:0]  iw_tgt_gp;
  logic        iw_tgt_gp_we;
  logic [23:0] iw_result;
  logic        iw_flush;
  logic [3:0]  iw_gp_read_addr1;
  logic [3:0]  iw_gp_read_addr2;
  logic [23:0] ow_gp_read_data1, ow_gp_read_data2, ow_mowb_result;
  logic [3:0]  ow_tgt_mowb_gp;
  logic        ow_tgt_mowb_gp_we;
  logic [15:0] ow_retire_cnt;
  logic [23:0] w4_rd1, w4_rd2, w4_res;
  logic [3:0]  w4_tgt;
  logic        w4_we;
  logic [3:0]  w4_cnt;

  always #5 iw_clk = ~iw_clk;

  stg5wb_gpregs u_dut (
    .iw_clk(iw_clk), .iw_rst_n(iw_rst_n),
    .iw_tgt_gp(iw_tgt_gp), .iw_tgt_gp_we(iw_tgt_gp_we),
    .iw_result(iw_result), .iw_flush(iw_flush),
    .iw_gp_read_addr1(iw_gp_read_addr1), .iw_gp_read_addr2(iw_gp_read_addr2),
    .ow_gp_read_data1(ow_gp_read_data1), .ow_gp_read_data2(ow_gp_read_data2),
    .ow_tgt_mowb_gp(ow_tgt_mowb_gp), .ow_tgt_mowb_gp_we(ow_tgt_mowb_gp_we),
    .ow_mowb_result(ow_mowb_result), .ow_retire_cnt(ow_retire_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, for the wrap case.
  stg5wb_gpregs #(.DATA_W(24), .GP_AW(4), .CNT_W(4)) u_dut4 (
    .iw_clk(iw_clk), .iw_rst_n(iw_rst_n),
    .iw_tgt_gp(iw_tgt_gp), .iw_tgt_gp_we(iw_tgt_gp_we),
    .iw_result(iw_result), .iw_flush(iw_flush),
    .iw_gp_read_addr1(iw_gp_read_addr1), .iw_gp_read_addr2(iw_gp_read_addr2),
    .ow_gp_read_data1(w4_rd1), .ow_gp_read_data2(w4_rd2),
    .ow_tgt_mowb_gp(w4_tgt), .ow_tgt_mowb_gp_we(w4_we),
    .ow_mowb_result(w4_res), .ow_retire_cnt(w4_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: register contents plus the one pending write-back.
  logic [23:0] m_gp [16];
  logic [3:0]  m_tgt;
  logic        m_we;
  logic [23:0] m_res;
  int          m_cnt;

  typedef struct {
    logic [3:0]  tgt;
    logic        we;
    logic        flush;
    logic [23:0] res;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [3:0]  e_tgt;
    logic        e_we;
    logic [23:0] e_res;
    logic [23:0] e_rd1;
    logic [23:0] e_rd2;
    int          e_cnt;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_gp[i] = '0;
    m_tgt = '0;
    m_we  = 1'b0;
    m_res = '0;
    m_cnt = 0;
  endtask

  function automatic logic [23:0] m_read(input logic [3:0] a);
    if (c_BYP && m_we && m_tgt == a) return m_res;
    return m_gp[a];
  endfunction

  task automatic model_check();
    chk("fwd_tgt", 32'(ow_tgt_mowb_gp), 32'(m_tgt));
    chk("fwd_we", 32'(ow_tgt_mowb_gp_we), 32'(m_we));
    chk("fwd_res", 32'(ow_mowb_result), 32'(m_res));
    chk("rd1", 32'(ow_gp_read_data1), 32'(m_read(iw_gp_read_addr1)));
    chk("rd2", 32'(ow_gp_read_data2), 32'(m_read(iw_gp_read_addr2)));
    chk("cnt16", 32'(ow_retire_cnt), 32'(m_cnt % 65536));
    chk("cnt4", 32'(w4_cnt), 32'(m_cnt % 16));
  endtask

  // One rising edge: advance the model, then compare just after the edge.
  task automatic tick();
    @(posedge iw_clk);
    if (m_we) begin
      m_gp[m_tgt] = m_res;
      m_cnt++;
    end
    m_tgt = iw_tgt_gp;
    m_we  = iw_tgt_gp_we & ~iw_flush;
    m_res = iw_result;
    #1;
    model_check();
  endtask

  task automatic drive(input logic [3:0] t, input logic we, input logic fl,
                       input logic [23:0] r, input logic [3:0] a1, input logic [3:0] a2);
    iw_tgt_gp = t; iw_tgt_gp_we = we; iw_flush = fl; iw_result = r;
    iw_gp_read_addr1 = a1; iw_gp_read_addr2 = a2;
  endtask

  task automatic do_reset();
    iw_rst_n = 1'b0;
    model_reset();
    @(posedge iw_clk);
    #1;
    iw_rst_n = 1'b1;
  endtask

  initial begin
    drive(4'd0, 1'b0, 1'b0, 24'd0, 4'd3, 4'd3);
    iw_rst_n = 1'b0;
    model_reset();
    #2;
    chk("rst_fwd_we", 32'(ow_tgt_mowb_gp_we), 32'd0);
    chk("rst_fwd_res", 32'(ow_mowb_result), 32'd0);
    chk("rst_cnt", 32'(ow_retire_cnt), 32'd0);
    chk("rst_rd1", 32'(ow_gp_read_data1), 32'd0);
    @(posedge iw_clk);
    #1;
    iw_rst_n = 1'b1;

    // {tgt,we,flush,res,ra1,ra2, e_tgt,e_we,e_res,e_rd1,e_rd2,e_cnt}
    vecs[0] = '{4'd5, 1'b1, 1'b0, 24'h123456, 4'd5, 4'd5, 4'd5, 1'b1, 24'h123456,
                c_BYP ? 24'h123456 : 24'h0, c_BYP ? 24'h123456 : 24'h0, 0};
    vecs[1] = '{4'd7, 1'b1, 1'b1, 24'hFFFFFF, 4'd5, 4'd7, 4'd7, 1'b0, 24'hFFFFFF,
                24'h123456, 24'h0, 1};
    vecs[2] = '{4'd2, 1'b1, 1'b0, 24'h000011, 4'd7, 4'd2, 4'd2, 1'b1, 24'h000011,
                24'h0, c_BYP ? 24'h000011 : 24'h0, 1};
    vecs[3] = '{4'd2, 1'b1, 1'b0, 24'h000022, 4'd2, 4'd2, 4'd2, 1'b1, 24'h000022,
                c_BYP ? 24'h000022 : 24'h000011, c_BYP ? 24'h000022 : 24'h000011, 2};
    vecs[4] = '{4'd0, 1'b0, 1'b0, 24'hABCDEF, 4'd2, 4'd2, 4'd0, 1'b0, 24'hABCDEF,
                24'h000022, 24'h000022, 3};
    vecs[5] = '{4'd0, 1'b1, 1'b0, 24'h000001, 4'd0, 4'd7, 4'd0, 1'b1, 24'h000001,
                c_BYP ? 24'h000001 : 24'h0, 24'h0, 3};
    vecs[6] = '{4'd9, 1'b1, 1'b0, 24'h000999, 4'd0, 4'd9, 4'd9, 1'b1, 24'h000999,
                24'h000001, c_BYP ? 24'h000999 : 24'h0, 4};
    vecs[7] = '{4'd9, 1'b1, 1'b0, 24'h000AAA, 4'd9, 4'd9, 4'd9, 1'b1, 24'h000AAA,
                c_BYP ? 24'h000AAA : 24'h000999, c_BYP ? 24'h000AAA : 24'h000999, 5};

    for (int v = 0; v < 8; v++) begin
      drive(vecs[v].tgt, vecs[v].we, vecs[v].flush, vecs[v].res, vecs[v].ra1, vecs[v].ra2);
      tick();
      chk($sformatf("vec%0d_tgt", v), 32'(ow_tgt_mowb_gp), 32'(vecs[v].e_tgt));
      chk($sformatf("vec%0d_we", v), 32'(ow_tgt_mowb_gp_we), 32'(vecs[v].e_we));
      chk($sformatf("vec%0d_res", v), 32'(ow_mowb_result), 32'(vecs[v].e_res));
      chk($sformatf("vec%0d_rd1", v), 32'(ow_gp_read_data1), 32'(vecs[v].e_rd1));
      chk($sformatf("vec%0d_rd2", v), 32'(ow_gp_read_data2), 32'(vecs[v].e_rd2));
      chk($sformatf("vec%0d_cnt", v), 32'(ow_retire_cnt), 32'(vecs[v].e_cnt));
    end

    // Mid-run reset with a pending write of r3 in the latch.
    do_reset();
    drive(4'd3, 1'b1, 1'b0, 24'h00ABCD, 4'd3, 4'd3);
    tick();
    chk("pre_rst_we", 32'(ow_tgt_mowb_gp_we), 32'd1);
    drive(4'd0, 1'b0, 1'b0, 24'd0, 4'd3, 4'd3);
    #2;
    iw_rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_we", 32'(ow_tgt_mowb_gp_we), 32'd0);
    chk("midrst_rd1", 32'(ow_gp_read_data1), 32'd0);
    @(posedge iw_clk);
    @(posedge iw_clk);
    #1;
    iw_rst_n = 1'b1;
    #1;
    chk("postrst_rd1", 32'(ow_gp_read_data1), 32'd0);
    chk("postrst_rd2", 32'(ow_gp_read_data2), 32'd0);
    chk("postrst_cnt", 32'(ow_retire_cnt), 32'd0);
    tick();
    chk("postrst_tick_rd1", 32'(ow_gp_read_data1), 32'd0);
    chk("postrst_tick_cnt", 32'(ow_retire_cnt), 32'd0);

    // Seventeen commits: 4-bit counter wraps to 1.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      drive(4'(k), 1'b1, 1'b0, 24'(k + 100), 4'(k), 4'd0);
      tick();
    end
    drive(4'd0, 1'b0, 1'b0, 24'd0, 4'd1, 4'd15);
    tick();
    chk("wrap_cnt4", 32'(w4_cnt), 32'd1);
    chk("wrap_cnt16", 32'(ow_retire_cnt), 32'd17);
    chk("wrap_r1", 32'(ow_gp_read_data1), 32'd101);
    chk("wrap_r15", 32'(ow_gp_read_data2), 32'd115);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] a1;
      a1 = 4'($urandom_range(0, 15));
      drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 7) == 0), 24'($urandom),
            a1, ($urandom_range(0, 3) == 0) ? a1 : 4'($urandom_range(0, 15)));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
